// File: rtl/irq_ctrl_pkg.sv
// ============================================================================
// Module : irq_ctrl_pkg
// Brief  : Board channel map, defaults and mode helper for the IRQ controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package irq_ctrl_pkg;

  localparam int INT_COM         = 0;
  localparam int INT_KBD         = 1;
  localparam int INT_SL811       = 2;
  localparam int IRQ_NUM_DEFAULT = 8;

  // Board default: every device holds its request line until serviced.
  localparam logic [31:0] IRQ_EDGE_MASK_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    IRQ_LEVEL = 1'b0,
    IRQ_EDGE  = 1'b1
  } irq_mode_e;

  function automatic irq_mode_e irq_mode(input logic [31:0] mask, input int idx);
    irq_mode = mask[idx] ? IRQ_EDGE : IRQ_LEVEL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_ctrl_if.sv
// ============================================================================
// Module : irq_ctrl_if
// Brief  : Request/mask/acknowledge bundle between devices, CP0 and irq_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface irq_ctrl_if #(
  parameter int NUM_IRQ  = 8,
  parameter int ID_WIDTH = 5
);
  logic [NUM_IRQ-1:0]  irq_in;
  logic [NUM_IRQ-1:0]  im;
  logic                ie;
  logic                ack;
  logic [ID_WIDTH-1:0] ack_id;
  logic [NUM_IRQ-1:0]  pending_raw;
  logic                has_int_pending;
  logic [ID_WIDTH-1:0] pending_id;
  logic                pending_valid;

  modport master (
    output irq_in, im, ie, ack, ack_id,
    input  pending_raw, has_int_pending, pending_id, pending_valid
  );

  modport slave (
    input  irq_in, im, ie, ack, ack_id,
    output pending_raw, has_int_pending, pending_id, pending_valid
  );
endinterface

`default_nettype wire

// File: rtl/irq_sync.sv
// ============================================================================
// Module : irq_sync
// Brief  : Multi-flop synchroniser for one asynchronous request line.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module irq_sync #(
  parameter int STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic d,
  output logic      q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain <= '0;
    else      chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
// Module : irq_ctrl
// Brief  : Per-channel edge/level interrupt latch, mask and priority encoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int                 NUM_IRQ     = IRQ_NUM_DEFAULT,
  parameter int                 ID_WIDTH    = 5,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0
) (
  input wire logic  clk,
  input wire logic  rst,
  irq_ctrl_if.slave bus
);

  logic [NUM_IRQ-1:0]  s;
  logic [NUM_IRQ-1:0]  s_d;
  logic [NUM_IRQ-1:0]  pending;
  logic [NUM_IRQ-1:0]  pending_nxt;
  logic [NUM_IRQ-1:0]  clr;
  logic [NUM_IRQ-1:0]  masked;
  logic [NUM_IRQ-1:0]  raw_q;
  logic                hip_q;
  logic                valid_q;
  logic [ID_WIDTH-1:0] id_q;

  // Highest set index wins; an empty vector encodes as channel 0.
  function automatic logic [ID_WIDTH-1:0] prio(input logic [NUM_IRQ-1:0] v);
    prio = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (v[i]) prio = ID_WIDTH'(i);
    end
  endfunction

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_chan
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.irq_in[i]),
      .q   (s[i])
    );
  end

  // An out-of-range ack_id matches no channel, so it has no effect.
  always_comb begin
    clr         = '0;
    pending_nxt = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr[i] = bus.ack && (bus.ack_id == ID_WIDTH'(i));
      if (irq_mode(32'(EDGE_MASK), i) == IRQ_EDGE)
        pending_nxt[i] = (s[i] & ~s_d[i]) | (pending[i] & ~clr[i]);
      else
        pending_nxt[i] = s[i];
    end
  end

  assign masked = pending & bus.im;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_d     <= '0;
      pending <= '0;
      raw_q   <= '0;
      hip_q   <= 1'b0;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      s_d     <= s;
      pending <= pending_nxt;
      raw_q   <= pending;
      hip_q   <= bus.ie & (|masked);
      valid_q <= |masked;
      id_q    <= prio(masked);
    end
  end

  assign bus.pending_raw     = raw_q;
  assign bus.has_int_pending = hip_q;
  assign bus.pending_valid   = valid_q;
  assign bus.pending_id      = id_q;

endmodule

`default_nettype wire
